// File: rtl/dsp_add_sched.sv
// Round-robin front end that shares one pipelined dsp_add among several requesters.
// A tag pipeline tracks each issued pair through the DSP. Sums go into a show-ahead response FIFO.
module dsp_add_sched #(
  parameter int  width      = 8,
  parameter int  num_req    = 4,
  parameter int  latency    = 2,
  parameter int  fifo_depth = 4,
  localparam int id_w       = (num_req > 1) ? $clog2(num_req) : 1
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [num_req-1:0]       req_valid,
  output logic [num_req-1:0]       req_ready,
  input  logic [num_req*width-1:0] req_a,
  input  logic [num_req*width-1:0] req_b,
  output logic [width-1:0]         dsp_a,
  output logic [width-1:0]         dsp_b,
  input  logic [width-1:0]         dsp_y,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [width-1:0]         rsp_data,
  output logic [id_w-1:0]          rsp_id
);

  localparam int stages = latency + 1;
  localparam int cnt_w  = $clog2(fifo_depth + 1);
  localparam int ptr_w  = (fifo_depth > 1) ? $clog2(fifo_depth) : 1;

  logic [width-1:0] a_slice [num_req];
  logic [width-1:0] b_slice [num_req];

  logic [id_w-1:0]  rr_ptr_reg;
  logic [id_w-1:0]  winner;
  logic [id_w-1:0]  cand;
  logic             found;
  logic             issue;
  logic [cnt_w-1:0] occ_reg;

  logic             tag_valid_reg [stages];
  logic [id_w-1:0]  tag_id_reg    [stages];

  logic [width-1:0] fifo_data_reg [fifo_depth];
  logic [id_w-1:0]  fifo_id_reg   [fifo_depth];
  logic [ptr_w-1:0] wr_ptr_reg;
  logic [ptr_w-1:0] rd_ptr_reg;
  logic [cnt_w-1:0] fifo_cnt_reg;
  logic             push;
  logic             pop;

  function automatic logic [ptr_w-1:0] ptr_inc(input logic [ptr_w-1:0] p);
    return (p == ptr_w'(fifo_depth - 1)) ? '0 : p + 1'b1;
  endfunction

  for (genvar gi = 0; gi < num_req; gi++) begin : g_req
    assign a_slice[gi]   = req_a[gi*width +: width];
    assign b_slice[gi]   = req_b[gi*width +: width];
    assign req_ready[gi] = issue && (winner == id_w'(gi));
  end

  // Search begins one past the last winner so every requester gets a turn.
  always_comb begin
    found  = 1'b0;
    winner = '0;
    cand   = '0;
    for (int k = 1; k <= num_req; k++) begin
      cand = id_w'((int'(rr_ptr_reg) + k) % num_req);
      if (!found && req_valid[cand]) begin
        found  = 1'b1;
        winner = cand;
      end
    end
  end

  // The registered occupancy is compared here, so a pop in this cycle cannot also let an issue through.
  // The reset term keeps req_ready low for as long as reset is held.
  assign issue = found && (occ_reg < cnt_w'(fifo_depth)) && reset;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rr_ptr_reg <= id_w'(num_req - 1);
      dsp_a      <= '0;
      dsp_b      <= '0;
    end else if (issue) begin
      rr_ptr_reg <= winner;
      dsp_a      <= a_slice[winner];
      dsp_b      <= b_slice[winner];
    end
  end

  for (genvar gi = 0; gi < stages; gi++) begin : g_tag
    if (gi == 0) begin : g_head
      always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
          tag_valid_reg[gi] <= 1'b0;
          tag_id_reg[gi]    <= '0;
        end else begin
          tag_valid_reg[gi] <= issue;
          tag_id_reg[gi]    <= winner;
        end
      end
    end else begin : g_body
      always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
          tag_valid_reg[gi] <= 1'b0;
          tag_id_reg[gi]    <= '0;
        end else begin
          tag_valid_reg[gi] <= tag_valid_reg[gi-1];
          tag_id_reg[gi]    <= tag_id_reg[gi-1];
        end
      end
    end
  end

  assign push      = tag_valid_reg[stages-1];
  assign rsp_valid = (fifo_cnt_reg != '0);
  assign pop       = rsp_valid && rsp_ready;
  assign rsp_data  = fifo_data_reg[rd_ptr_reg];
  assign rsp_id    = fifo_id_reg[rd_ptr_reg];

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < fifo_depth; i++) begin
        fifo_data_reg[i] <= '0;
        fifo_id_reg[i]   <= '0;
      end
      wr_ptr_reg <= '0;
    end else if (push) begin
      fifo_data_reg[wr_ptr_reg] <= dsp_y;
      fifo_id_reg[wr_ptr_reg]   <= tag_id_reg[stages-1];
      wr_ptr_reg                <= ptr_inc(wr_ptr_reg);
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rd_ptr_reg <= '0;
    end else if (pop) begin
      rd_ptr_reg <= ptr_inc(rd_ptr_reg);
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      fifo_cnt_reg <= '0;
    end else begin
      case ({push, pop})
        2'b10:   fifo_cnt_reg <= fifo_cnt_reg + 1'b1;
        2'b01:   fifo_cnt_reg <= fifo_cnt_reg - 1'b1;
        default: fifo_cnt_reg <= fifo_cnt_reg;
      endcase
    end
  end

  // Occupancy counts tags in flight plus FIFO entries, which keeps the FIFO from ever overflowing.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      occ_reg <= '0;
    end else begin
      case ({issue, pop})
        2'b10:   occ_reg <= occ_reg + 1'b1;
        2'b01:   occ_reg <= occ_reg - 1'b1;
        default: occ_reg <= occ_reg;
      endcase
    end
  end

endmodule
